// File: rtl/fd_ctrl_pkg.sv
// fd_ctrl_pkg: shared types and encodings for the fd_control_unit block.
// The instruction-field constants follow the RV32I base encoding.
package fd_ctrl_pkg;

  // Control sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  // Instruction classes produced by the decoder
  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_ADDI    = 3'd1,
    CLS_LW      = 3'd2,
    CLS_SW      = 3'd3,
    CLS_SYSTEM  = 3'd4,
    CLS_ILLEGAL = 3'd5
  } instr_class_e;

  // Major opcodes (IR[6:0])
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ADDI   = 7'b0010011;
  localparam logic [6:0] OPC_LW     = 7'b0000011;
  localparam logic [6:0] OPC_SW     = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Datapath operand/write-back select (OP_MEM_I)
  localparam logic [1:0] OPM_ALU_RB  = 2'b00;
  localparam logic [1:0] OPM_ALU_OFF = 2'b01;
  localparam logic [1:0] OPM_LOAD_WB = 2'b10;
  localparam logic [1:0] OPM_STORE   = 2'b11;

  // funct7/funct3 pattern selecting subtract among R-type ops
  localparam logic [6:0] FUNCT7_SUB    = 7'b0100000;
  localparam logic [2:0] FUNCT3_ADDSUB = 3'b000;

endpackage

// File: rtl/fd_ctrl_if.sv
// fd_ctrl_if: bundle between the control unit (master) and the datapath (slave).
interface fd_ctrl_if #(
  parameter int PC_WIDTH = 32
);
  logic                start;
  logic [31:0]         instruction;
  logic                PC_load;
  logic [PC_WIDTH-1:0] PC_add;
  logic                WE_reg;
  logic                WE_mem;
  logic [1:0]          OP_MEM_I;
  logic                ADD_SUB;
  logic                busy;
  logic                halted;
  logic                illegal;

  modport master (
    input  start, instruction,
    output PC_load, PC_add, WE_reg, WE_mem, OP_MEM_I, ADD_SUB, busy, halted, illegal
  );

  modport slave (
    output start, instruction,
    input  PC_load, PC_add, WE_reg, WE_mem, OP_MEM_I, ADD_SUB, busy, halted, illegal
  );
endinterface

// File: rtl/fd_ctrl_decoder.sv
// fd_ctrl_decoder: purely combinational instruction classifier. Produces the
// instruction class plus the ALU direction and datapath operand select.
module fd_ctrl_decoder
  import fd_ctrl_pkg::*;
(
  input  logic [31:0]  ir,
  output instr_class_e iclass,
  output logic         add_sub,
  output logic [1:0]   op_mem_i
);

  // Register-index and immediate fields are consumed by the datapath, not here
  logic unused_ir_fields_s;
  assign unused_ir_fields_s = ^{ir[24:15], ir[11:7]};

  // Classify on opcode and derive the per-class datapath controls
  always_comb begin
    iclass   = CLS_ILLEGAL;
    op_mem_i = OPM_ALU_RB;
    add_sub  = 1'b0;
    case (ir[6:0])
      OPC_RTYPE: begin
        iclass   = CLS_RTYPE;
        op_mem_i = OPM_ALU_RB;
        if ((ir[31:25] == FUNCT7_SUB) && (ir[14:12] == FUNCT3_ADDSUB)) begin
          add_sub = 1'b1;
        end else begin
          add_sub = 1'b0;
        end
      end
      OPC_ADDI: begin
        iclass   = CLS_ADDI;
        op_mem_i = OPM_ALU_OFF;
      end
      OPC_LW: begin
        iclass   = CLS_LW;
        op_mem_i = OPM_LOAD_WB;
      end
      OPC_SW: begin
        iclass   = CLS_SW;
        op_mem_i = OPM_STORE;
      end
      OPC_SYSTEM: begin
        iclass = CLS_SYSTEM;
      end
      default: begin
        iclass = CLS_ILLEGAL;
      end
    endcase
  end

endmodule

// File: rtl/fd_control_unit.sv
// fd_control_unit: multi-cycle sequencer for the fetch/decode/regfile/dmem
// datapath. Strobes are Moore decodes of the state register; only the IDLE
// start load of the PC depends on the start input.
// Optional feature macro: FD_CTRL_PERF_EN adds cycle_cnt and instret_cnt.
module fd_control_unit
  import fd_ctrl_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4),
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(0)
) (
  input  logic         clk,
  input  logic         rst,
  fd_ctrl_if.master    bus
`ifdef FD_CTRL_PERF_EN
  ,
  output logic [31:0]  cycle_cnt,
  output logic [31:0]  instret_cnt
`endif
);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic                illegal_q, illegal_d;

  logic [PC_WIDTH-1:0] pc_next_s;
  logic [31:0]         dec_ir_s;
  instr_class_e        dec_class_s;
  logic                dec_add_sub_s;
  logic [1:0]          dec_op_s;

  logic                pc_load_s;
  logic [PC_WIDTH-1:0] pc_add_s;
  logic                we_reg_s;
  logic                we_mem_s;
  logic [1:0]          op_mem_i_s;
  logic                add_sub_s;
  logic                busy_s;
  logic                halted_s;
  logic                start_clear_s;

  assign pc_next_s = pc_q + PC_STEP;

  // In DECODE the decoder looks at the live instruction so the HALT decision
  // is made in the same cycle the IR is captured; afterwards it sees the IR
  always_comb begin
    if (state_q == ST_DECODE) begin
      dec_ir_s = bus.instruction;
    end else begin
      dec_ir_s = ir_q;
    end
  end

  assign ir_d = dec_ir_s;

  fd_ctrl_decoder u_decoder (
    .ir       (dec_ir_s),
    .iclass   (dec_class_s),
    .add_sub  (dec_add_sub_s),
    .op_mem_i (dec_op_s)
  );

  // Next-state, PC shadow update and strobe decode
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    illegal_d     = illegal_q;
    pc_load_s     = 1'b0;
    pc_add_s      = pc_q;
    we_reg_s      = 1'b0;
    we_mem_s      = 1'b0;
    op_mem_i_s    = OPM_ALU_RB;
    add_sub_s     = 1'b0;
    busy_s        = 1'b1;
    halted_s      = 1'b0;
    start_clear_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_s = 1'b0;
        if (bus.start) begin
          pc_load_s     = 1'b1;
          pc_add_s      = RESET_PC;
          pc_d          = RESET_PC;
          start_clear_s = 1'b1;
          state_d       = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (dec_class_s)
          CLS_SYSTEM: begin
            illegal_d = 1'b0;
            state_d   = ST_HALT;
          end
          CLS_ILLEGAL: begin
            illegal_d = 1'b1;
            state_d   = ST_HALT;
          end
          default: begin
            state_d = ST_EXEC;
          end
        endcase
      end
      ST_EXEC: begin
        op_mem_i_s = dec_op_s;
        add_sub_s  = dec_add_sub_s;
        case (dec_class_s)
          CLS_RTYPE, CLS_ADDI: state_d = ST_WB;
          CLS_LW, CLS_SW:      state_d = ST_MEM;
          default: begin
            illegal_d = 1'b1;
            state_d   = ST_HALT;
          end
        endcase
      end
      ST_MEM: begin
        op_mem_i_s = dec_op_s;
        add_sub_s  = dec_add_sub_s;
        if (dec_class_s == CLS_SW) begin
          we_mem_s  = 1'b1;
          pc_load_s = 1'b1;
          pc_add_s  = pc_next_s;
          pc_d      = pc_next_s;
          state_d   = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        op_mem_i_s = dec_op_s;
        add_sub_s  = dec_add_sub_s;
        we_reg_s   = 1'b1;
        pc_load_s  = 1'b1;
        pc_add_s   = pc_next_s;
        pc_d       = pc_next_s;
        state_d    = ST_FETCH;
      end
      ST_HALT: begin
        busy_s   = 1'b0;
        halted_s = 1'b1;
        if (bus.start) begin
          illegal_d     = 1'b0;
          start_clear_s = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Architectural state: FSM, PC shadow, IR and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.PC_load  = pc_load_s;
  assign bus.PC_add   = pc_add_s;
  assign bus.WE_reg   = we_reg_s;
  assign bus.WE_mem   = we_mem_s;
  assign bus.OP_MEM_I = op_mem_i_s;
  assign bus.ADD_SUB  = add_sub_s;
  assign bus.busy     = busy_s;
  assign bus.halted   = halted_s;
  assign bus.illegal  = illegal_q;

`ifdef FD_CTRL_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instret_cnt_q, instret_cnt_d;
  logic        retire_s;

  // A retiring cycle is any PC advance while busy; the IDLE start load is not busy
  assign retire_s = pc_load_s & busy_s;

  // Counter next values: clear on a start from IDLE/HALT, else count
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (start_clear_s) begin
      cycle_cnt_d   = 32'd0;
      instret_cnt_d = 32'd0;
    end else begin
      if (busy_s) begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
      end else begin
        cycle_cnt_d = cycle_cnt_q;
      end
      if (retire_s) begin
        instret_cnt_d = instret_cnt_q + 32'd1;
      end else begin
        instret_cnt_d = instret_cnt_q;
      end
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q   <= 32'd0;
      instret_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_fd_control_unit.sv
// tb_fd_control_unit: self-checking bench for fd_control_unit. The bench acts
// as the datapath PC register plus instruction memory, and predicts the full
// per-cycle strobe trace of a program from the instruction semantics.
// With FD_CTRL_PERF_EN defined the counters are checked every cycle as well.
module tb_fd_control_unit;

  typedef struct packed {
    logic        pc_load;
    logic [31:0] pc_add;
    logic        we_reg;
    logic        we_mem;
    logic [1:0]  op;
    logic        add_sub;
    logic        busy;
    logic        halted;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  fd_ctrl_if #(.PC_WIDTH(32)) bus ();
  fd_ctrl_if #(.PC_WIDTH(32)) wbus ();

`ifdef FD_CTRL_PERF_EN
  logic [31:0] cyc_cnt, ins_cnt, wcyc_cnt, wins_cnt;
`endif

  fd_control_unit #(.PC_WIDTH(32), .PC_STEP(32'd4), .RESET_PC(32'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FD_CTRL_PERF_EN
    ,
    .cycle_cnt   (cyc_cnt),
    .instret_cnt (ins_cnt)
`endif
  );

  // Second instance starting near the top of the address space for PC wrap
  fd_control_unit #(.PC_WIDTH(32), .PC_STEP(32'd4), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wbus)
`ifdef FD_CTRL_PERF_EN
    ,
    .cycle_cnt   (wcyc_cnt),
    .instret_cnt (wins_cnt)
`endif
  );

  // Datapath stand-in: PC register and instruction memory
  logic [31:0] imem [0:63];
  logic [31:0] pc_reg = 32'd0;
  always @(posedge clk) if (bus.PC_load === 1'b1) pc_reg <= bus.PC_add;
  assign bus.instruction  = imem[pc_reg[7:2]];
  assign wbus.instruction = 32'h0050_0093;

  exp_t exp_q[$];

  function automatic exp_t sample();
    exp_t e;
    e.pc_load = bus.PC_load;
    e.pc_add  = (bus.PC_load === 1'b1) ? bus.PC_add : 32'd0;
    e.we_reg  = bus.WE_reg;
    e.we_mem  = bus.WE_mem;
    e.op      = bus.OP_MEM_I;
    e.add_sub = bus.ADD_SUB;
    e.busy    = bus.busy;
    e.halted  = bus.halted;
    e.illegal = bus.illegal;
    return e;
  endfunction

  function automatic string fmt(exp_t e);
    return $sformatf("ld=%b add=%h wr=%b wm=%b op=%b sub=%b busy=%b halt=%b ill=%b",
                     e.pc_load, e.pc_add, e.we_reg, e.we_mem, e.op, e.add_sub,
                     e.busy, e.halted, e.illegal);
  endfunction

  // 0 R-type, 1 addi, 2 lw, 3 sw, 4 system, 5 unsupported
  function automatic int kind(logic [6:0] opc);
    if (opc == 7'h33) return 0;
    if (opc == 7'h13) return 1;
    if (opc == 7'h03) return 2;
    if (opc == 7'h23) return 3;
    if (opc == 7'h73) return 4;
    return 5;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) imem[i] = 32'hFFFF_FFFF;
  endtask

  task automatic do_reset();
    bus.start  = 1'b0;
    wbus.start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Expected cycle trace: start cycle, then per instruction FETCH, DECODE and
  // its execute/memory/retire cycles, ending with halt_cycles HALT cycles
  task automatic build_trace(input int halt_cycles);
    exp_t e;
    logic [31:0] pc, ins;
    int k;
    bit done;
    exp_q.delete();
    e = '0; e.pc_load = 1'b1; e.pc_add = 32'd0;
    exp_q.push_back(e);
    pc = 32'd0;
    done = 1'b0;
    while (!done) begin
      ins = imem[pc[7:2]];
      k = kind(ins[6:0]);
      e = '0; e.busy = 1'b1;
      exp_q.push_back(e);
      exp_q.push_back(e);
      if (k >= 4) begin
        e = '0; e.halted = 1'b1; e.illegal = (k == 5);
        for (int i = 0; i < halt_cycles; i++) exp_q.push_back(e);
        done = 1'b1;
      end else begin
        e = '0; e.busy = 1'b1;
        e.op = 2'(k);
        e.add_sub = (k == 0) && (ins[31:25] == 7'b0100000) && (ins[14:12] == 3'b000);
        exp_q.push_back(e);
        if (k == 2) exp_q.push_back(e);
        e.pc_load = 1'b1;
        e.pc_add  = pc + 32'd4;
        if (k == 3) e.we_mem = 1'b1; else e.we_reg = 1'b1;
        exp_q.push_back(e);
        pc = pc + 32'd4;
      end
    end
  endtask

  task automatic run_check(input string name, input bit rand_start);
    exp_t obs;
    int cyc_e = 0;
    int ins_e = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b1;
      else if (rand_start && exp_q[i].busy) bus.start = 1'($urandom_range(0, 1));
      else bus.start = 1'b0;
      #1;
      obs = sample();
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cycle %0d: got {%s} expected {%s}", name, i, fmt(obs), fmt(exp_q[i]));
      end
`ifdef FD_CTRL_PERF_EN
      if (i > 0) begin
        checks++;
        if (cyc_cnt !== 32'(cyc_e) || ins_cnt !== 32'(ins_e)) begin
          errors++;
          $display("FAIL %s_perf cycle %0d: got cycle=%0d instret=%0d expected cycle=%0d instret=%0d",
                   name, i, cyc_cnt, ins_cnt, cyc_e, ins_e);
        end
        if (exp_q[i].busy) cyc_e++;
        if (exp_q[i].busy && exp_q[i].pc_load) ins_e++;
      end
`endif
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    exp_t obs;
    do_reset();
    #1;
    obs = sample();
    checks++;
    if (obs !== exp_t'(0)) begin
      errors++;
      $display("FAIL reset_state: got {%s} expected all zero", fmt(obs));
    end
  endtask

  task automatic test_addi();
    do_reset(); clear_mem();
    imem[0] = 32'h0050_0093;
    imem[1] = 32'h0000_0073;
    build_trace(3);
    run_check("addi", 1'b0);
  endtask

  task automatic test_sub();
    do_reset(); clear_mem();
    imem[0] = 32'h0050_0093;
    imem[1] = 32'h0030_0113;
    imem[2] = 32'h4020_81B3;
    imem[3] = 32'h0000_0073;
    build_trace(3);
    run_check("sub", 1'b0);
  endtask

  task automatic test_sw_lw();
    do_reset(); clear_mem();
    imem[0] = 32'h0050_0093;
    imem[1] = 32'h0020_2423;
    imem[2] = 32'h0080_2183;
    imem[3] = 32'h0000_0073;
    build_trace(3);
    run_check("sw_lw", 1'b0);
  endtask

  task automatic test_halt_restart();
    exp_t obs;
    do_reset(); clear_mem();
    build_trace(20);
    run_check("illegal_halt", 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    obs = sample();
    checks++;
    if (obs !== exp_t'(0)) begin
      errors++;
      $display("FAIL restart_idle: got {%s} expected all zero", fmt(obs));
    end
    imem[0] = 32'h0000_0073;
    build_trace(3);
    run_check("system_halt", 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 4);
    case (k)
      0: begin
        r[6:0]   = 7'h33;
        r[31:25] = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
        if ($urandom_range(0, 1) == 1) r[14:12] = 3'b000;
      end
      1: r[6:0] = 7'h13;
      2: r[6:0] = 7'h03;
      3: r[6:0] = 7'h23;
      default: r[6:0] = 7'h33;
    endcase
    return r;
  endfunction

  task automatic test_random();
    logic [31:0] t;
    int n;
    for (int p = 0; p < 8; p++) begin
      do_reset(); clear_mem();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) imem[i] = rand_instr();
      if ($urandom_range(0, 1) == 1) begin
        imem[n] = 32'h0000_0073;
      end else begin
        t = $urandom;
        while (kind(t[6:0]) != 5) t = $urandom;
        imem[n] = t;
      end
      build_trace(2);
      run_check($sformatf("random%0d", p), 1'b1);
    end
  endtask

  task automatic test_reset_midrun();
    exp_t obs;
    bit seen;
    logic [31:0] pc_snap;
    seen = 1'b0;
    do_reset(); clear_mem();
    imem[0] = 32'h0050_0093;
    imem[1] = 32'h0020_2423;
    imem[2] = 32'h0000_0073;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (bus.WE_mem === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_midrun_wait: got no WE_mem within 30 cycles expected one");
    end else begin
      pc_snap = pc_reg;
      rst = 1'b1;
      #1;
      obs = sample();
      checks++;
      if (obs !== exp_t'(0)) begin
        errors++;
        $display("FAIL reset_midrun_async: got {%s} expected all zero", fmt(obs));
      end
      @(posedge clk);
      #1;
      checks++;
      if (pc_reg !== pc_snap || bus.PC_load !== 1'b0) begin
        errors++;
        $display("FAIL reset_midrun_pc: got pc=%h load=%b expected pc=%h load=0",
                 pc_reg, bus.PC_load, pc_snap);
      end
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    @(negedge clk);
    wbus.start = 1'b1;
    #1;
    checks++;
    if (wbus.PC_load !== 1'b1 || wbus.PC_add !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_start: got load=%b add=%h expected load=1 add=fffffffc",
               wbus.PC_load, wbus.PC_add);
    end
    @(negedge clk);
    wbus.start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (wbus.WE_reg !== 1'b1 || wbus.PC_load !== 1'b1 || wbus.PC_add !== 32'h0) begin
      errors++;
      $display("FAIL wrap_retire: got we_reg=%b load=%b add=%h expected we_reg=1 load=1 add=00000000",
               wbus.WE_reg, wbus.PC_load, wbus.PC_add);
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    wbus.start = 1'b0;
    clear_mem();
    test_reset();
    test_addi();
    test_sub();
    test_sw_lw();
    test_halt_restart();
    test_reset_midrun();
    test_pc_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fd_control_unit.md
# fd_control_unit

Multi-cycle control unit that sequences the fetch/decode/register-file/data-memory datapath. It owns the architectural PC shadow and reads the 32-bit fetched instruction. Per instruction, it drives the datapath strobes (PC_load, PC_add, WE_reg, WE_mem, OP_MEM_I, ADD_SUB) through a fixed state sequence. Supports R-type add/sub, addi, lw and sw; SYSTEM opcode halts cleanly, and any other opcode halts with an error flag.

## Interface
- PC_WIDTH, 32: width of PC shadow and PC_add.
- PC_STEP, 4: PC increment per retired instruction.
- RESET_PC, 0: PC value loaded on start.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin execution from IDLE, or restart from HALT.
- instruction  in  32  fetched instruction from datapath instruction_out.
- PC_load  out  1  PC register load strobe.
- PC_add  out  PC_WIDTH  next PC value presented to the PC register.
- WE_reg  out  1  register-file write enable.
- WE_mem  out  1  data-memory write enable.
- OP_MEM_I  out  2  datapath op: 00 ALU with Rb, 01 ALU with offset, 10 load write-back, 11 store.
- ADD_SUB  out  1  ALU op: 1 = subtract, 0 = add.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- illegal  out  1  high in HALT when entered on an unsupported opcode.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE:
  - All strobes are 0.
  - When start=1: PC_load=1, PC_add=RESET_PC, pc_q<=RESET_PC, then go to FETCH.
- FETCH: no strobes. Allows the PC register output and the instruction memory to settle. Go to DECODE.
- DECODE: latch instruction into IR. Classify on opcode IR[6:0]:
  - 0110011: R-type.
  - 0010011: addi.
  - 0000011: lw.
  - 0100011: sw.
  - 1110011: SYSTEM, go to HALT with illegal=0.
  - Any other opcode: go to HALT with illegal=1.
- EXEC: drive OP_MEM_I and ADD_SUB from IR.
  - ADD_SUB=1 only for R-type with funct7=0100000 and funct3=000.
  - OP_MEM_I and ADD_SUB hold constant from EXEC through the last state of the instruction.
  - R-type and addi go to WB; lw and sw go to MEM.
- MEM:
  - sw: WE_mem=1, PC_load=1, PC_add=pc_q+PC_STEP, pc_q updates, then go to FETCH (retire).
  - lw: no strobe, go to WB.
- WB: WE_reg=1, PC_load=1, PC_add=pc_q+PC_STEP, pc_q updates, then go to FETCH (retire).
- HALT:
  - All strobes are 0.
  - start=1 clears illegal and goes to IDLE.
- PC arithmetic is modulo 2^PC_WIDTH; 0xFFFFFFFC+4 wraps to 0.
- WE_reg and WE_mem are never high in the same cycle.
- Each write strobe is high for exactly one cycle per instruction.

## Timing
- All outputs are registered-state Moore decodes, except PC_add/PC_load in IDLE, which depend on start.
- Reset values:
  - State IDLE, pc_q=RESET_PC, IR=0.
  - All strobes 0, busy=0, halted=0, illegal=0, counters 0.
- Reset is asynchronous: asserting rst in any state drops every strobe in the same cycle, with no completion of the in-flight write.
- Latency per instruction, FETCH to retire inclusive:
  - R-type and addi: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- start is ignored while busy=1.

## Configuration
- FD_CTRL_PERF_EN:
  - When defined, adds outputs cycle_cnt[31:0] and instret_cnt[31:0].
  - cycle_cnt increments every cycle with busy=1.
  - instret_cnt increments on each retiring cycle (MEM for sw, WB otherwise); the IDLE start load does not count.
  - Both counters wrap at 2^32 and clear on rst or on start from IDLE/HALT.
- When undefined, the ports and counter logic are absent.

## Structure
- Package fd_ctrl_pkg holds:
  - State enum.
  - Opcode constants (OPC_RTYPE, OPC_ADDI, OPC_LW, OPC_SW, OPC_SYSTEM).
  - OP_MEM_I codes.
  - FUNCT7_SUB.
- One combinational sub-module, fd_ctrl_decoder: IR in, instruction class, ADD_SUB and OP_MEM_I out.

## Test plan
- Reset: assert rst mid-run → all strobes, busy, halted and illegal read 0 immediately; PC_add not loaded.
- addi x1,x0,5 (0x00500093) after start → PC_load=1 with PC_add=0 in IDLE; 4 cycles later WB shows WE_reg=1, OP_MEM_I=01, ADD_SUB=0, PC_load=1, PC_add=4.
- sub x3,x1,x2 (0x402081B3) → ADD_SUB=1 and OP_MEM_I=00 steady from EXEC to WB; WE_reg only in WB.
- sw x2,8(x0) (0x00202423) then lw x3,8(x0) (0x00802183):
  - sw: WE_mem=1 for one cycle in MEM, WE_reg stays 0.
  - lw: 5 cycles, OP_MEM_I=10, WE_reg=1 in WB.
  - PC_add advances 4 then 8.
- 0xFFFFFFFF → halted=1, illegal=1, no strobes for 20 cycles; start → IDLE with illegal=0. 0x00000073 → halted=1, illegal=0.
- With FD_CTRL_PERF_EN, after addi+sw+lw: instret_cnt=3, cycle_cnt=13.
